// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of one gcd core among NUM_REQ requesters with a one-entry response buffer
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [NUM_REQ*32-1:0]  req_a_i,
  input  logic [NUM_REQ*32-1:0]  req_b_i,
  input  logic [NUM_REQ-1:0]     req_v_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [31:0]            resp_data_o,
  output logic [NUM_REQ-1:0]     resp_v_o,
  input  logic [NUM_REQ-1:0]     resp_yumi_i,
  output logic [31:0]            core_a_o,
  output logic [31:0]            core_b_o,
  output logic                   core_v_o,
  input  logic                   core_ready_i,
  input  logic [31:0]            core_data_i,
  input  logic                   core_v_i,
  output logic                   core_yumi_o,
  output logic [CNT_W-1:0]       done_count_o
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic core_busy_r, buf_v_r, buf_drain, issue_ok, gnt_any;
  logic [ID_W-1:0] rr_ptr_r, core_owner_r, buf_owner_r, gnt_idx;
  logic [31:0] buf_data_r;
  logic [CNT_W-1:0] done_count_r;
  assign issue_ok = reset_n_i & ~core_busy_r & core_ready_i;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    core_a_o = '0;
    core_b_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (issue_ok && !gnt_any && req_v_i[i] && ID_W'(i) >= rr_ptr_r) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (issue_ok && !gnt_any && req_v_i[i] && ID_W'(i) < rr_ptr_r) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_any && gnt_idx == ID_W'(i)) begin
        core_a_o = req_a_i[i*32 +: 32];
        core_b_o = req_b_i[i*32 +: 32];
      end
  end
  assign req_ready_o  = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
  assign core_v_o     = gnt_any;
  assign resp_v_o     = buf_v_r ? NUM_REQ'(1) << buf_owner_r : '0;
  assign resp_data_o  = buf_data_r;
  assign buf_drain    = |(resp_v_o & resp_yumi_i);
  assign core_yumi_o  = core_v_i & core_busy_r & (~buf_v_r | buf_drain);
  assign done_count_o = done_count_r;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      core_busy_r  <= 1'b0;
      buf_v_r      <= 1'b0;
      rr_ptr_r     <= '0;
      core_owner_r <= '0;
      buf_owner_r  <= '0;
      buf_data_r   <= '0;
      done_count_r <= '0;
    end else begin
      if (gnt_any) begin
        core_busy_r  <= 1'b1;
        core_owner_r <= gnt_idx;
        rr_ptr_r     <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (core_yumi_o) begin
        buf_data_r  <= core_data_i;
        buf_owner_r <= core_owner_r;
        buf_v_r     <= 1'b1;
        core_busy_r <= 1'b0;
      end else if (buf_drain)
        buf_v_r <= 1'b0;
      if (buf_drain)
        done_count_r <= done_count_r + 1'b1;
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: scoreboard bench for gcd_arbiter with a behavioural gcd core attached
module tb_gcd_arbiter;
  localparam int N = 4;
  typedef struct packed {logic [1:0] own; logic [31:0] data;} exp_t;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_n_i;
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [N*32-1:0] req_a_i, req_b_i;
  logic [N-1:0] req_v_i, req_ready_o, resp_v_o, resp_yumi_i;
  logic [31:0] resp_data_o, core_a_o, core_b_o, core_data_i;
  logic core_v_o, core_ready_i, core_v_i, core_yumi_o;
  logic [3:0] done_count_o;
  logic [1:0] st;
  logic [2:0] dly;
  int jobs_started;
  int errors = 0;
  int checks = 0;
  int issued [N];
  int limit [N];
  exp_t exp_q [$];
  exp_t e;
  always_comb begin
    req_a_i = '0;
    req_b_i = '0;
    for (int i = 0; i < N; i++) begin
      req_a_i[i*32 +: 32] = op_a[i];
      req_b_i[i*32 +: 32] = op_b[i];
    end
  end
  gcd_arbiter #(.NUM_REQ(N), .CNT_W(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .core_a_o(core_a_o), .core_b_o(core_b_o), .core_v_o(core_v_o),
    .core_ready_i(core_ready_i), .core_data_i(core_data_i), .core_v_i(core_v_i),
    .core_yumi_o(core_yumi_o), .done_count_o(done_count_o)
  );
  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  assign core_ready_i = (st == 2'd0);
  assign core_v_i = (st == 2'd2);
  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st <= 2'd0;
      dly <= 3'd0;
      core_data_i <= '0;
      jobs_started <= 0;
    end else begin
      case (st)
        2'd0: if (core_v_o) begin
          core_data_i <= gcd(core_a_o, core_b_o);
          dly <= 3'd2;
          st <= 2'd1;
          jobs_started <= jobs_started + 1;
        end
        2'd1: if (dly == 0) st <= 2'd2; else dly <= dly - 1'b1;
        default: if (core_yumi_o) st <= 2'd0;
      endcase
    end
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  always @(negedge clk_i) begin
    if (reset_n_i && |(resp_v_o & resp_yumi_i)) begin
      if (exp_q.size() == 0)
        chk("resp_unexpected", {resp_v_o, resp_data_o}, 0);
      else begin
        e = exp_q.pop_front();
        chk("resp", {resp_v_o, resp_data_o}, {N'(1) << e.own, e.data});
      end
    end
  end
  task automatic push(input int o, input int d);
    exp_q.push_back({2'(o), 32'(d)});
  endtask
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk_i);
    hs = req_v_i & req_ready_o;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        issued[i]++;
        if (issued[i] >= limit[i]) req_v_i[i] = 1'b0;
      end
  endtask
  task automatic do_reset();
    reset_n_i = 1'b0;
    req_v_i = '0;
    resp_yumi_i = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      limit[i] = 0;
    end
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, exp_q.size(), 0);
  endtask
  task automatic rr_ops();
    op_a[0] = 12; op_b[0] = 8;
    op_a[1] = 15; op_b[1] = 10;
    op_a[2] = 14; op_b[2] = 21;
    op_a[3] = 27; op_b[3] = 18;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int g [N];
    g[0] = 4; g[1] = 5; g[2] = 7; g[3] = 9;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    reset_n_i = 1'b0;
    req_v_i = '0;
    resp_yumi_i = '0;
    #12;
    chk("reset_outs", {req_ready_o, resp_v_o, resp_data_o, core_v_o, core_yumi_o, done_count_o}, 0);
    do_reset();
    op_a[0] = 48; op_b[0] = 18; limit[0] = 1;
    push(0, 6);
    resp_yumi_i = 4'hF;
    req_v_i = 4'b0001;
    n = 0;
    while (!core_v_i && n < 50) begin step(); n++; end
    chk("t1_core_done", core_v_i, 1);
    step();
    chk("t1_latency", {resp_v_o, resp_data_o}, {4'b0001, 32'd6});
    drain("t1", 50);
    chk("t1_issues", jobs_started, 1);
    chk("t1_done", done_count_o, 1);
    do_reset();
    rr_ops();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, g[i]);
    for (int i = 0; i < N; i++) limit[i] = 2;
    resp_yumi_i = 4'hF;
    req_v_i = 4'hF;
    drain("t2", 400);
    chk("t2_done", done_count_o, 8);
    do_reset();
    op_a[2] = 100; op_b[2] = 75; limit[2] = 1;
    op_a[3] = 21; op_b[3] = 14; limit[3] = 1;
    push(2, 25);
    push(3, 7);
    req_v_i = 4'b1100;
    n = 0;
    while (!(resp_v_o == 4'b0100 && core_v_i) && n < 100) begin step(); n++; end
    for (int k = 0; k < 2; k++) begin
      chk("t3_hold", {resp_v_o, resp_data_o, core_v_i, core_yumi_o}, {4'b0100, 32'd25, 1'b1, 1'b0});
      step();
    end
    resp_yumi_i = 4'b0100;
    #1 chk("t3_refill", core_yumi_o, 1);
    step();
    chk("t3_next", {resp_v_o, resp_data_o}, {4'b1000, 32'd7});
    resp_yumi_i = 4'b1000;
    drain("t3", 20);
    chk("t3_done", done_count_o, 2);
    do_reset();
    op_a[1] = 35; op_b[1] = 14; limit[1] = 1;
    push(1, 7);
    req_v_i = 4'b0010;
    n = 0;
    while (resp_v_o != 4'b0010 && n < 50) begin step(); n++; end
    resp_yumi_i = 4'b0100;
    step();
    resp_yumi_i = '0;
    chk("t4_misdir", {resp_v_o, resp_data_o, done_count_o}, {4'b0010, 32'd7, 4'd0});
    resp_yumi_i = 4'b0010;
    drain("t4", 10);
    chk("t4_done", done_count_o, 1);
    do_reset();
    op_a[0] = 100; op_b[0] = 40; limit[0] = 1;
    resp_yumi_i = 4'hF;
    req_v_i = 4'b0001;
    n = 0;
    while (st != 2'd1 && n < 50) begin step(); n++; end
    req_v_i = 4'hF;
    #2 reset_n_i = 1'b0;
    #1 chk("t5_async", {req_ready_o, resp_v_o, resp_data_o, core_a_o, core_b_o, core_v_o, core_yumi_o, done_count_o}, 0);
    do_reset();
    op_a[0] = 9; op_b[0] = 6; limit[0] = 1;
    push(0, 3);
    resp_yumi_i = 4'hF;
    req_v_i = 4'b0001;
    drain("t5", 50);
    chk("t5_done", done_count_o, 1);
    do_reset();
    rr_ops();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < N; i++) push(i, g[i]);
    push(0, 4);
    limit[0] = 5; limit[1] = 4; limit[2] = 4; limit[3] = 4;
    resp_yumi_i = 4'hF;
    req_v_i = 4'hF;
    drain("t6", 800);
    chk("t6_wrap", done_count_o, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
